// File: rtl/reg_file_pkg.sv
// Shared widths and constants for the register file and its companion helpers.
package reg_file_pkg;

  localparam int DEF_DATA_W    = 16;
  localparam int DEF_ADDR_W    = 4;
  localparam int DEF_DATA3_REG = 1;

  // Companion helper constants: zero-extender source width and default write target.
  localparam int         ZEXT_SRC_W    = 8;
  localparam logic [3:0] WRITE_REG_DEF = 4'd1;

endpackage

// File: rtl/reg_file_zext8to16.sv
// Zero-extends an 8-bit value to 16 bits: upper byte 0, lower byte = input.
module zext8to16
  import reg_file_pkg::*;
(
  input  logic [ZEXT_SRC_W-1:0] in_i,
  output logic [15:0]           out_o
);

  assign out_o = {{(16 - ZEXT_SRC_W){1'b0}}, in_i};

endmodule

// File: rtl/reg_file.sv
// 2**ADDR_W x DATA_W register file: two combinational read ports, one fixed-register
// read port (Data3), one synchronous write port; register 0 is hard-wired to zero.
module reg_file
  import reg_file_pkg::*;
#(
  parameter int DATA_W    = DEF_DATA_W,
  parameter int ADDR_W    = DEF_ADDR_W,
  parameter int DATA3_REG = DEF_DATA3_REG
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic [ADDR_W-1:0] Read1,
  input  logic [ADDR_W-1:0] Read2,
  input  logic [ADDR_W-1:0] WriteReg,
  input  logic [DATA_W-1:0] WriteData,
  input  logic              RegWrite,
  output logic [DATA_W-1:0] Data1,
  output logic [DATA_W-1:0] Data2,
  output logic [DATA_W-1:0] Data3
);

  localparam int NREGS = 2 ** ADDR_W;

  logic [DATA_W-1:0] regs_q [NREGS];
  logic [DATA_W-1:0] regs_d [NREGS];
  logic [DATA_W-1:0] wr_data;

  // The low byte of the write data travels through the shared zero-extender; its upper
  // byte is always zero, so merging it back in leaves the stored value unchanged.
  generate
    if (DATA_W >= 16) begin : g_zext
      logic [15:0] zext_out;

      zext8to16 u_zext (
        .in_i  (WriteData[ZEXT_SRC_W-1:0]),
        .out_o (zext_out)
      );

      always_comb begin
        wr_data        = WriteData;
        wr_data[15:8]  = WriteData[15:8] | zext_out[15:8];
        wr_data[7:0]   = zext_out[7:0];
      end
    end else begin : g_no_zext
      assign wr_data = WriteData;
    end
  endgenerate

  always_comb begin
    for (int i = 0; i < NREGS; i++) begin
      regs_d[i] = regs_q[i];
    end
    if (RegWrite && (WriteReg != '0)) begin
      regs_d[WriteReg] = wr_data;
    end
    regs_d[0] = '0;
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      for (int i = 0; i < NREGS; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NREGS; i++) begin
        regs_q[i] <= regs_d[i];
      end
    end
  end

  // Reads see the registered array only, so a same-edge write is visible after the edge.
  assign Data1 = regs_q[Read1];
  assign Data2 = regs_q[Read2];
  assign Data3 = regs_q[DATA3_REG];

endmodule

// File: tb/tb_reg_file.sv
// Directed-vector bench for reg_file with hand-computed expected values.
module tb_reg_file;

  localparam int DATA_W = 16;
  localparam int ADDR_W = 4;

  logic              clock;
  logic              reset_n;
  logic [ADDR_W-1:0] Read1;
  logic [ADDR_W-1:0] Read2;
  logic [ADDR_W-1:0] WriteReg;
  logic [DATA_W-1:0] WriteData;
  logic              RegWrite;
  logic [DATA_W-1:0] Data1;
  logic [DATA_W-1:0] Data2;
  logic [DATA_W-1:0] Data3;

  int n_vec;
  int n_err;

  reg_file #(
    .DATA_W    (DATA_W),
    .ADDR_W    (ADDR_W),
    .DATA3_REG (1)
  ) dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .Read1     (Read1),
    .Read2     (Read2),
    .WriteReg  (WriteReg),
    .WriteData (WriteData),
    .RegWrite  (RegWrite),
    .Data1     (Data1),
    .Data2     (Data2),
    .Data3     (Data3)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [DATA_W-1:0] got,
                       input logic [DATA_W-1:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Advance past one rising edge and let outputs settle.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic wr(input logic [ADDR_W-1:0] addr, input logic [DATA_W-1:0] data);
    WriteReg  = addr;
    WriteData = data;
    RegWrite  = 1'b1;
    tick();
    RegWrite  = 1'b0;
  endtask

  initial begin
    n_vec     = 0;
    n_err     = 0;
    reset_n   = 1'b0;
    Read1     = '0;
    Read2     = '0;
    WriteReg  = 4'd5;
    WriteData = 16'hFFFF;
    RegWrite  = 1'b1;

    // Reset edge with a pending write: everything must read zero.
    tick();
    RegWrite = 1'b0;
    reset_n  = 1'b1;
    for (int a = 0; a < 16; a++) begin
      Read1 = a[ADDR_W-1:0];
      Read2 = 4'(15 - a);
      #1;
      check($sformatf("rst_d1_r%0d", a), Data1, 16'h0000);
      check($sformatf("rst_d2_r%0d", 15 - a), Data2, 16'h0000);
    end
    check("rst_d3", Data3, 16'h0000);

    // Load-upper pattern into r1, observed on Data3.
    for (int i = 0; i < 16; i++) begin
      wr(4'd1, 16'(i << 8));
      check($sformatf("lui_d3_i%0d", i), Data3, 16'(i << 8));
    end

    // Independent read ports.
    wr(4'd3, 16'hA5A5);
    wr(4'd7, 16'h1234);
    Read1 = 4'd3;
    Read2 = 4'd7;
    #1;
    check("rd_r3", Data1, 16'hA5A5);
    check("rd_r7", Data2, 16'h1234);
    check("d3_hold", Data3, 16'h0F00);
    Read1 = 4'd7;
    #1;
    check("same_d1", Data1, 16'h1234);
    check("same_d2", Data2, 16'h1234);

    // Register 0 ignores writes.
    wr(4'd0, 16'hBEEF);
    Read1 = 4'd0;
    #1;
    check("r0_zero", Data1, 16'h0000);

    // Write enable low leaves contents alone.
    wr(4'd2, 16'h1111);
    WriteReg  = 4'd2;
    WriteData = 16'h2222;
    RegWrite  = 1'b0;
    tick();
    Read1 = 4'd2;
    #1;
    check("we_low_r2", Data1, 16'h1111);

    // Same-cycle read of the written address: old value before, new value after.
    wr(4'd4, 16'h1357);
    Read1     = 4'd4;
    WriteReg  = 4'd4;
    WriteData = 16'h00FF;
    RegWrite  = 1'b1;
    #1;
    check("nobyp_before", Data1, 16'h1357);
    tick();
    RegWrite = 1'b0;
    check("nobyp_after", Data1, 16'h00FF);

    // Full-width storage.
    wr(4'd15, 16'hFFFF);
    Read2 = 4'd15;
    #1;
    check("full_w_r15", Data2, 16'hFFFF);
    wr(4'd14, 16'h8001);
    Read2 = 4'd14;
    #1;
    check("full_w_r14", Data2, 16'h8001);

    // Mid-sequence reset discards contents and the concurrent write.
    reset_n   = 1'b0;
    WriteReg  = 4'd9;
    WriteData = 16'h5A5A;
    RegWrite  = 1'b1;
    tick();
    RegWrite = 1'b0;
    reset_n  = 1'b1;
    Read1 = 4'd3;
    Read2 = 4'd9;
    #1;
    check("mid_rst_r3", Data1, 16'h0000);
    check("mid_rst_r9", Data2, 16'h0000);
    check("mid_rst_d3", Data3, 16'h0000);
    wr(4'd9, 16'hCAFE);
    check("post_rst_r9", Data2, 16'hCAFE);
    wr(4'd1, 16'h7E81);
    check("post_rst_d3", Data3, 16'h7E81);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
